mem_stage: RTL

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_pkg.sv | 35 +++
 rtl/load_align.sv | 37 +++
 rtl/mem_stage.sv | 132 +++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the memory stage: load/store opcodes, FSM state, byte enables.
package mem_pkg;
  localparam logic [5:0] OP_LB  = 6'd32;
  localparam logic [5:0] OP_LH  = 6'd33;
  localparam logic [5:0] OP_LWL = 6'd34;
  localparam logic [5:0] OP_LW  = 6'd35;
  localparam logic [5:0] OP_LBU = 6'd36;
  localparam logic [5:0] OP_LHU = 6'd37;
  localparam logic [5:0] OP_LWR = 6'd38;
  localparam logic [5:0] OP_SB  = 6'd40;
  localparam logic [5:0] OP_SH  = 6'd41;
  localparam logic [5:0] OP_SWL = 6'd42;
  localparam logic [5:0] OP_SW  = 6'd43;
  localparam logic [5:0] OP_SWR = 6'd46;

  typedef enum logic {IDLE, WAIT} state_t;
  typedef logic [3:0] be_t;

  function automatic logic is_load(input logic [5:0] op);
    return op inside {OP_LB, OP_LH, OP_LWL, OP_LW, OP_LBU, OP_LHU, OP_LWR};
  endfunction

  function automatic logic is_store(input logic [5:0] op);
    return op inside {OP_SB, OP_SH, OP_SWL, OP_SW, OP_SWR};
  endfunction

  // Byte offset actually used: halfword/word accesses are forced to natural alignment.
  function automatic logic [1:0] eff_off(input logic [5:0] op, input logic [1:0] a);
    case (op)
      OP_LH, OP_LHU, OP_SH: return {a[1], 1'b0};
      OP_LW, OP_SW:         return 2'b00;
      default:              return a;
    endcase
  endfunction
endpackage

// File: rtl/load_align.sv
// Load data alignment: lane select, sign/zero extension and lwl/lwr merge with rt.
module load_align
  import mem_pkg::*;
(
  input  logic [5:0]  opcode,
  input  logic [1:0]  off,
  input  logic [31:0] rdata,
  input  logic [31:0] rt,
  output logic [31:0] data
);
  logic [4:0]  sh;
  logic [31:0] rs;
  logic [7:0]  b;
  logic [15:0] h;
  logic [31:0] lwl_v, lwr_v;

  assign sh = {off, 3'b000};
  assign rs = rdata >> sh;
  assign b  = rs[7:0];
  assign h  = off[1] ? rdata[31:16] : rdata[15:0];
  // lwl fills from the top down, lwr from the bottom up; untouched bytes keep rt
  assign lwl_v = (rdata << {~off, 3'b000}) | (rt & (32'h00FF_FFFF >> sh));
  assign lwr_v = rs | (rt & ~(32'hFFFF_FFFF >> sh));

  always_comb begin
    data = rdata;
    case (opcode)
      OP_LB:   data = {{24{b[7]}}, b};
      OP_LBU:  data = {24'd0, b};
      OP_LH:   data = {{16{h[15]}}, h};
      OP_LHU:  data = {16'd0, h};
      OP_LWL:  data = lwl_v;
      OP_LWR:  data = lwr_v;
      default: data = rdata;
    endcase
  end
endmodule

// File: rtl/mem_stage.sv
// Pipeline memory stage with IDLE/WAIT handshake FSM.
// MEM_MISALIGN_TRAP_EN: trap misaligned lh/lhu/sh/lw/sw instead of forcing alignment.
module mem_stage
  import mem_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  opcode,
  input  logic [4:0]  rd,
  input  logic        register_write,
  input  logic [31:0] result,
  input  logic [31:0] address,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  output logic [5:0]  opcode_o,
  output logic [4:0]  rd_o,
  output logic        register_write_o,
  output logic [31:0] result_o,
  output logic        stall_o
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic        addr_error_o
`endif
);
  state_t      state;
  logic [5:0]  op_q;
  logic [4:0]  rd_q;
  logic        rw_q;
  logic [31:0] rt_q;
  logic [31:0] addr_q;
  logic        misalign, issue, st_q;
  logic [31:0] ld_data, wd_st;
  be_t         be_st;

`ifdef MEM_MISALIGN_TRAP_EN
  assign misalign = (((opcode == OP_LH) || (opcode == OP_LHU) || (opcode == OP_SH)) && address[0]) ||
                    (((opcode == OP_LW) || (opcode == OP_SW)) && (address[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign issue   = (is_load(opcode) || is_store(opcode)) && !misalign;
  assign stall_o = !rst && ((state == IDLE) ? issue : !mem_ack);
  assign st_q    = is_store(op_q);

  load_align u_align (
    .opcode (op_q),
    .off    (addr_q[1:0]),
    .rdata  (mem_rdata),
    .rt     (rt_q),
    .data   (ld_data)
  );

  always_comb begin
    be_st = 4'b1111;
    wd_st = rt_q;
    case (op_q)
      OP_SB:  begin be_st = 4'b0001 << addr_q[1:0]; wd_st = {4{rt_q[7:0]}}; end
      OP_SH:  begin be_st = 4'b0011 << addr_q[1:0]; wd_st = {2{rt_q[15:0]}}; end
      OP_SWL: begin be_st = 4'b1111 >> ~addr_q[1:0]; wd_st = rt_q >> {~addr_q[1:0], 3'b000}; end
      OP_SWR: begin be_st = 4'b1111 << addr_q[1:0]; wd_st = rt_q << {addr_q[1:0], 3'b000}; end
      default: ;
    endcase
  end

  // request fields come from latched state, so they stay constant through WAIT
  assign mem_req   = (state == WAIT);
  assign mem_we    = mem_req && st_q;
  assign mem_addr  = mem_req ? {addr_q[31:2], 2'b00} : 32'd0;
  assign mem_be    = mem_req ? (st_q ? be_st : 4'b1111) : 4'b0000;
  assign mem_wdata = (mem_req && st_q) ? wd_st : 32'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      op_q             <= '0;
      rd_q             <= '0;
      rw_q             <= 1'b0;
      rt_q             <= '0;
      addr_q           <= '0;
      opcode_o         <= '0;
      rd_o             <= '0;
      register_write_o <= 1'b0;
      result_o         <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
      addr_error_o     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (issue) begin
            op_q             <= opcode;
            rd_q             <= rd;
            rw_q             <= register_write;
            rt_q             <= result;
            addr_q           <= {address[31:2], eff_off(opcode, address[1:0])};
            register_write_o <= 1'b0;
            state            <= WAIT;
          end else begin
            opcode_o         <= opcode;
            rd_o             <= rd;
            register_write_o <= register_write && !misalign;
            result_o         <= result;
`ifdef MEM_MISALIGN_TRAP_EN
            addr_error_o     <= misalign;
`endif
          end
        end
        WAIT: begin
          if (mem_ack) begin
            opcode_o         <= op_q;
            rd_o             <= rd_q;
            register_write_o <= rw_q && is_load(op_q);
            result_o         <= is_load(op_q) ? ld_data : rt_q;
`ifdef MEM_MISALIGN_TRAP_EN
            addr_error_o     <= 1'b0;
`endif
            state            <= IDLE;
          end else begin
            register_write_o <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
